// File: rtl/uart_pkg.sv
// Shared UART definitions: default frame width and the transmit feeder's
// controller states.
package uart_pkg;

    localparam int D_BITS_DEF = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2
    } feeder_state_t;

endpackage

// File: rtl/uart_tx_feeder_if.sv
// Producer-side and transmitter-side signals of the UART transmit feeder.
interface uart_tx_feeder_if
    import uart_pkg::*;
#(
    parameter int D_BITS = D_BITS_DEF,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = $clog2(DEPTH) + 1
);
    logic [D_BITS-1:0] i_wr_data;
    logic              i_wr_valid;
    logic              o_wr_ready;
    logic              i_flush;
    logic [D_BITS-1:0] o_tx_data;
    logic              o_tx_enable;
    logic              i_tx_rdy;
    logic              i_tx_done;
    logic [CNT_W-1:0]  o_level;
    logic              o_busy;
    logic              o_overflow;

    // Environment side: producer plus transmitter.
    modport master (
        output i_wr_data, i_wr_valid, i_flush, i_tx_rdy, i_tx_done,
        input  o_wr_ready, o_tx_data, o_tx_enable, o_level, o_busy, o_overflow
    );

    modport slave (
        input  i_wr_data, i_wr_valid, i_flush, i_tx_rdy, i_tx_done,
        output o_wr_ready, o_tx_data, o_tx_enable, o_level, o_busy, o_overflow
    );

endinterface

// File: rtl/uart_tx_feeder_fifo.sv
// Synchronous FIFO with pointer-based storage, occupancy counter and flush.
// Flush overrides push and pop in the same cycle.
module sync_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = D_BITS_DEF,
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] level,
    output logic [CNT_W-1:0] level_nxt
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == CNT_W'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign head    = mem[rd_ptr];

    always_comb begin
        level_nxt = level;
        if (flush) begin
            level_nxt = '0;
        end else begin
            level_nxt = level + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Pointers are exactly log2(DEPTH) wide, so they wrap on their own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            level <= level_nxt;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + AW'(1);
                if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers producer bytes and hands them to the UART transmitter one frame
// at a time, pacing on the transmitter's ready/done handshake.
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int D_BITS = D_BITS_DEF,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic             i_clk,
    input  logic             reset,
    uart_tx_feeder_if.slave  bus
);

    feeder_state_t     state;
    feeder_state_t     state_nxt;
    logic              launch;
    logic              fifo_full;
    logic              fifo_empty;
    logic [D_BITS-1:0] fifo_head;
    logic [CNT_W-1:0]  fifo_level;
    logic [CNT_W-1:0]  fifo_level_nxt;
    logic [D_BITS-1:0] tx_data;
    logic              tx_enable;
    logic              busy;
    logic              overflow;

    sync_fifo #(
        .WIDTH (D_BITS),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (i_clk),
        .rst_n     (reset),
        .push      (bus.i_wr_valid),
        .pop       (launch),
        .flush     (bus.i_flush),
        .wr_data   (bus.i_wr_data),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level),
        .level_nxt (fifo_level_nxt)
    );

    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty && bus.i_tx_rdy && !bus.i_flush) begin
                    launch    = 1'b1;
                    state_nxt = LAUNCH;
                end
            end
            LAUNCH:    state_nxt = WAIT_DONE;
            WAIT_DONE: if (bus.i_tx_done) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Busy is registered from next-state values so it tracks state and level
    // on the same edge.
    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) begin
            tx_data   <= '0;
            tx_enable <= 1'b0;
            busy      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            tx_enable <= launch;
            if (launch) tx_data <= fifo_head;
            busy <= (state_nxt != IDLE) || (fifo_level_nxt != '0);
            if (bus.i_flush) begin
                overflow <= 1'b0;
            end else if (bus.i_wr_valid && fifo_full) begin
                overflow <= 1'b1;
            end
        end
    end

    assign bus.o_wr_ready  = !fifo_full;
    assign bus.o_tx_data   = tx_data;
    assign bus.o_tx_enable = tx_enable;
    assign bus.o_level     = fifo_level;
    assign bus.o_busy      = busy;
    assign bus.o_overflow  = overflow;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder: vector table, directed corner sequences and a
// randomized run against a queue-based reference model.
module tb_uart_tx_feeder;

  localparam int DEPTH = 16;

  logic i_clk = 1'b0;
  logic reset = 1'b1;

  always #5 i_clk = ~i_clk;

  uart_tx_feeder_if #(.D_BITS(8), .DEPTH(DEPTH)) bus ();

  uart_tx_feeder #(.D_BITS(8), .DEPTH(DEPTH)) dut (
    .i_clk (i_clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic       wv;
    logic [7:0] wd;
    logic       fl;
    logic       rdy;
    logic       done;
    logic [4:0] lvl;
    logic       wr_rdy;
    logic       en;
    logic [7:0] data;
    logic       busy;
    logic       ovf;
  } vec_t;

  vec_t tbl [13];

  int n_tests = 0;
  int n_fail  = 0;

  // reference model
  logic [7:0] mq [$];
  bit         m_in_frame, m_en, m_ovf, m_busy;
  logic [7:0] m_data;
  bit         model_on = 0;

  // transmitter model
  bit         tx_auto = 0;
  bit         tx_busy = 0;
  bit         tx_stall = 0;
  bit         spur_en = 0;
  int         tx_cnt = 0;
  int         dly_min = 10;
  int         dly_max = 10;

  logic [7:0] emitted [$];
  int         peak = 0;
  bit         saw_full = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [16:0] dut_vec();
    return {bus.o_level, bus.o_wr_ready, bus.o_tx_enable, bus.o_tx_data,
            bus.o_busy, bus.o_overflow};
  endfunction

  function automatic logic [16:0] model_vec();
    return {5'(mq.size()), (mq.size() != DEPTH), m_en, m_data, m_busy, m_ovf};
  endfunction

  // Queue semantics: a frame is in flight from launch until a done pulse
  // arriving after the enable cycle; pop sees pre-edge contents, push sees
  // the pre-edge full condition.
  task automatic model_step();
    bit launch, full_pre;
    launch   = !m_in_frame && (mq.size() != 0) && bus.i_tx_rdy && !bus.i_flush;
    full_pre = (mq.size() == DEPTH);
    if (m_in_frame && !m_en && bus.i_tx_done) m_in_frame = 0;
    m_en = launch;
    if (launch) begin
      m_data = mq.pop_front();
      m_in_frame = 1;
    end
    if (bus.i_flush) begin
      mq.delete();
      m_ovf = 0;
    end else if (bus.i_wr_valid) begin
      if (full_pre) m_ovf = 1;
      else mq.push_back(bus.i_wr_data);
    end
    m_busy = m_in_frame || (mq.size() != 0);
  endtask

  task automatic tx_update();
    bus.i_tx_done = 1'b0;
    if (tx_cnt > 0) begin
      tx_cnt--;
      if (tx_cnt == 0) begin
        bus.i_tx_done = 1'b1;
        tx_busy = 0;
      end
    end else if (spur_en && !tx_busy && !bus.o_tx_enable && $urandom_range(29, 0) == 0) begin
      bus.i_tx_done = 1'b1;
    end
    if (bus.o_tx_enable) begin
      tx_cnt  = $urandom_range(dly_max, dly_min);
      tx_busy = 1;
    end
    bus.i_tx_rdy = !tx_busy && !tx_stall;
  endtask

  task automatic cycle();
    if (model_on) model_step();
    @(posedge i_clk);
    #1;
    if (model_on) check("model_cycle", 32'(dut_vec()), 32'(model_vec()));
    if (bus.o_tx_enable) emitted.push_back(bus.o_tx_data);
    if (int'(bus.o_level) > peak) peak = int'(bus.o_level);
    if (!bus.o_wr_ready) saw_full = 1;
    if (tx_auto) tx_update();
  endtask

  task automatic do_reset();
    model_on = 0;
    tx_auto  = 0;
    spur_en  = 0;
    bus.i_wr_valid = 1'b0;
    bus.i_wr_data  = 8'h00;
    bus.i_flush    = 1'b0;
    bus.i_tx_rdy   = 1'b0;
    bus.i_tx_done  = 1'b0;
    reset = 1'b0;
    #1;
    check("reset_state", 32'(dut_vec()), 32'({5'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0}));
    mq.delete();
    m_in_frame = 0; m_en = 0; m_data = 8'h00; m_ovf = 0; m_busy = 0;
    tx_cnt = 0; tx_busy = 0;
    emitted.delete();
    peak = 0; saw_full = 0;
    @(negedge i_clk);
    reset = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1);
  end

  initial begin
    logic [7:0] held;
    int k;

    // wv wd fl rdy done | lvl wr_rdy en data busy ovf
    tbl[0]  = '{1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 5'd1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 5'd1, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 5'd2, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 8'h44, 1'b0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 8'h11, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd3, 1'b1, 1'b0, 8'h11, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd3, 1'b1, 1'b0, 8'h11, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 8'h55, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 8'h11, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 8'h11, 1'b0, 1'b0};

    // vector table: single byte, done ignored in LAUNCH, push+pop, flush in IDLE
    do_reset();
    for (int i = 0; i < 13; i++) begin
      bus.i_wr_valid = tbl[i].wv;
      bus.i_wr_data  = tbl[i].wd;
      bus.i_flush    = tbl[i].fl;
      bus.i_tx_rdy   = tbl[i].rdy;
      bus.i_tx_done  = tbl[i].done;
      @(posedge i_clk);
      #1;
      check($sformatf("vec%0d", i), 32'(dut_vec()),
            32'({tbl[i].lvl, tbl[i].wr_rdy, tbl[i].en, tbl[i].data, tbl[i].busy, tbl[i].ovf}));
    end

    // burst of 16 into a stalled transmitter, overflow write, then drain
    do_reset();
    model_on = 1; tx_auto = 1; tx_stall = 1; dly_min = 10; dly_max = 10;
    for (int i = 0; i < DEPTH; i++) begin
      bus.i_wr_valid = 1'b1;
      bus.i_wr_data  = 8'(i + 1);
      cycle();
    end
    bus.i_wr_data = 8'h77;
    cycle();
    bus.i_wr_valid = 1'b0;
    check("peak_level", 32'(peak), 32'(DEPTH));
    check("full_not_ready", 32'(bus.o_wr_ready), 32'd0);
    check("full_level", 32'(bus.o_level), 32'(DEPTH));
    check("overflow_set", 32'(bus.o_overflow), 32'd1);
    tx_stall = 0;
    bus.i_tx_rdy = 1'b1;
    k = 0;
    while (!(emitted.size() >= DEPTH && !bus.o_busy) && k < 400) begin
      cycle();
      k++;
    end
    repeat (20) cycle();
    check("burst_count", 32'(emitted.size()), 32'(DEPTH));
    for (int i = 0; i < DEPTH && i < emitted.size(); i++)
      check($sformatf("burst_order%0d", i), 32'(emitted[i]), 32'(i + 1));
    check("overflow_sticky", 32'(bus.o_overflow), 32'd1);

    // flush while a frame is in WAIT_DONE
    emitted.delete();
    tx_stall = 1;
    bus.i_tx_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.i_wr_valid = 1'b1;
      bus.i_wr_data  = 8'hA0 + 8'(i);
      cycle();
    end
    bus.i_wr_valid = 1'b0;
    tx_stall = 0;
    bus.i_tx_rdy = 1'b1;
    k = 0;
    while (emitted.size() == 0 && k < 20) begin
      cycle();
      k++;
    end
    check("flush_launch_seen", 32'(emitted.size()), 32'd1);
    repeat (3) cycle();
    held = bus.o_tx_data;
    bus.i_flush = 1'b1;
    cycle();
    bus.i_flush = 1'b0;
    check("flush_level", 32'(bus.o_level), 32'd0);
    check("flush_overflow", 32'(bus.o_overflow), 32'd0);
    check("flush_data_held", 32'(bus.o_tx_data), 32'hA0);
    check("flush_busy_frame", 32'(bus.o_busy), 32'd1);
    k = 0;
    while (bus.o_busy && k < 60) begin
      cycle();
      k++;
    end
    repeat (20) cycle();
    check("flush_no_more_frames", 32'(emitted.size()), 32'd1);
    check("flush_data_final", 32'(bus.o_tx_data), 32'(held));

    // asynchronous reset between clock edges while in WAIT_DONE
    do_reset();
    model_on = 1; tx_auto = 1; tx_stall = 1; dly_min = 10; dly_max = 10;
    for (int i = 0; i < 3; i++) begin
      bus.i_wr_valid = 1'b1;
      bus.i_wr_data  = 8'h3C + 8'(i);
      cycle();
    end
    bus.i_wr_valid = 1'b0;
    tx_stall = 0;
    bus.i_tx_rdy = 1'b1;
    k = 0;
    while (emitted.size() == 0 && k < 10) begin
      cycle();
      k++;
    end
    repeat (2) cycle();
    check("pre_reset_level", 32'(bus.o_level), 32'd2);
    #2;
    model_on = 0;
    reset = 1'b0;
    #1;
    check("areset_enable", 32'(bus.o_tx_enable), 32'd0);
    check("areset_data", 32'(bus.o_tx_data), 32'd0);
    check("areset_level", 32'(bus.o_level), 32'd0);
    check("areset_wr_ready", 32'(bus.o_wr_ready), 32'd1);
    check("areset_busy", 32'(bus.o_busy), 32'd0);

    // randomized traffic with variable frame length, stalls and stray dones
    do_reset();
    model_on = 1; tx_auto = 1; tx_stall = 0; spur_en = 1;
    dly_min = 1; dly_max = 12;
    bus.i_tx_rdy = 1'b1;
    k = 5;
    for (int c = 0; c < 3000; c++) begin
      if (c % 400 == 0) k = int'($urandom_range(9, 1));
      bus.i_wr_valid = ($urandom_range(9, 0) < k);
      bus.i_wr_data  = 8'($urandom);
      bus.i_flush    = ($urandom_range(149, 0) == 0);
      if ($urandom_range(19, 0) == 0) tx_stall = !tx_stall;
      cycle();
    end
    bus.i_wr_valid = 1'b0;
    bus.i_flush    = 1'b0;
    tx_stall = 0;
    k = 0;
    while (bus.o_busy && k < 400) begin
      cycle();
      k++;
    end
    check("random_drained", 32'(bus.o_busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_feeder.md
Name: uart_tx_feeder

Overview:
- Upstream stage of the UART transmit path: buffers bytes from a producer in a synchronous FIFO.
- Drains the FIFO one byte per frame into the transmitter (i_data / i_tx_enable), pacing on the transmitter's o_tx_rdy / o_tx_done.
- Lets producers burst bytes at clock rate without tracking baud timing.

Parameters:
- D_BITS, 8, data width per frame; matches transmitter D_BITS.
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- CNT_W, $clog2(DEPTH)+1, width of the fill-level output.

Ports:
- i_clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- i_wr_data  input  D_BITS  byte from producer.
- i_wr_valid  input  1  producer offers i_wr_data.
- o_wr_ready  output  1  FIFO can accept; equals !full.
- i_flush  input  1  synchronous FIFO clear.
- o_tx_data  output  D_BITS  to transmitter i_data.
- o_tx_enable  output  1  to transmitter i_tx_enable; 1-cycle start pulse.
- i_tx_rdy  input  1  from transmitter o_tx_rdy; high when idle.
- i_tx_done  input  1  from transmitter o_tx_done; 1-cycle pulse at end of stop bit.
- o_level  output  CNT_W  current FIFO occupancy, 0..DEPTH.
- o_busy  output  1  frame in flight or FIFO non-empty.
- o_overflow  output  1  sticky: write attempted while full.

Behaviour:
- Reset (reset=0, async): pointers 0, o_level=0, o_wr_ready=1, o_tx_enable=0, o_tx_data=0, o_busy=0, o_overflow=0, FSM=IDLE.
- Write accepted on a rising edge with i_wr_valid && o_wr_ready.
  - o_wr_ready is !full only; no combinational path from the pop side.
  - A write while full is dropped and sets o_overflow. o_overflow clears only on reset or i_flush.
- FSM states: IDLE, LAUNCH, WAIT_DONE.
- IDLE: if level>0 && i_tx_rdy && !i_flush:
  - register o_tx_data <= FIFO head
  - pop head
  - o_tx_enable <= 1
  - go to LAUNCH
- LAUNCH: o_tx_enable is high for exactly this one cycle. Next edge: o_tx_enable <= 0, go to WAIT_DONE.
- WAIT_DONE: hold o_tx_data stable. On i_tx_done=1, go to IDLE. A new launch is possible in the following IDLE cycle if i_tx_rdy=1.
- Latency: a byte accepted into an empty FIFO at edge N is seen on o_tx_enable during the cycle after edge N+1 (2 edges). No bypass path.
- Back-to-back: a done pulse at edge M gives the next o_tx_enable after edge M+1 (i_tx_rdy permitting).
- i_tx_done outside WAIT_DONE is ignored.
- Simultaneous push and pop with 0<level<DEPTH: both occur, level unchanged.
  - When full, push is refused even if a pop occurs the same edge.
  - When empty, no pop.
- Pointers are log2(DEPTH) bits and wrap naturally. The level counter is CNT_W bits and never exceeds DEPTH.
- i_flush (sync, 1 cycle): pointers and level <= 0, o_overflow <= 0. Flush wins over a same-cycle write (write dropped, o_overflow unaffected).
  - Flush does not abort a frame in LAUNCH/WAIT_DONE. FSM completes normally and o_tx_data holds.
  - Flush in IDLE blocks launch that cycle.
- o_busy = (FSM != IDLE) || level != 0; registered.
- Reset mid-frame: everything returns to reset values immediately. The transmitter shares the same reset.

Decomposition:
- Shared package uart_pkg:
  - feeder FSM state enum (IDLE, LAUNCH, WAIT_DONE)
  - default D_BITS constant, shared with transmitter/receiver
- Sub-module sync_fifo (params WIDTH, DEPTH):
  - dual-pointer register array with push/pop/flush
  - outputs full, empty, level, head data
- The feeder top holds the FSM, overflow flag and output registers, and instantiates sync_fifo.

Test Plan:
- Single byte: write 0xA5 into empty FIFO, i_tx_rdy=1 -> o_tx_enable pulses 1 cycle, 2 edges after accept, o_tx_data=0xA5. o_busy stays 1 until 1 cycle after i_tx_done, then o_level=0, o_busy=0.
- Burst/order: write 0x01..0x10 (16 bytes, DEPTH=16) back-to-back with model transmitter (done 10 cycles after enable) -> o_level peaks at 16, o_wr_ready=0 at full. Bytes emitted in order 0x01..0x10, one enable per done.
- Overflow: fill 16 bytes with i_tx_rdy=0, write 0x77 -> write dropped, o_overflow=1, o_level=16. Release i_tx_rdy -> 0x77 never transmitted.
- Simultaneous push/pop: level=3, write on the same edge as an IDLE launch -> o_level stays 3, launched byte is the oldest.
- Flush mid-frame: 5 bytes queued, flush during WAIT_DONE -> current frame's o_tx_data held until done, then no further o_tx_enable. o_level=0, o_overflow=0.
- Async reset mid-frame: assert reset=0 in WAIT_DONE between clock edges -> o_tx_enable=0, o_tx_data=0, o_level=0, o_wr_ready=1 immediately without waiting for i_clk.
